// File: rtl/conv_pkg.sv
// conv_pkg: shared types and sizing helpers for the streaming KxK conv.
// Holds the FSM state enum, accumulator/output sizing and saturation.
package conv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READY,
        S_RUN,
        S_DRAIN
    } state_t;

    // Wide enough to hold K*K full-scale products without overflow.
    function automatic int acc_width(input int wl, input int k);
        return 2 * wl + $clog2(k * k);
    endfunction

    // Outputs per dimension; partial trailing stride steps are dropped.
    function automatic int out_dim(input int n, input int k, input int s);
        return (n - k) / s + 1;
    endfunction

    // Clamp v to the signed range of an ow-bit result.
    function automatic logic signed [63:0] saturate(
        input logic signed [63:0] v,
        input int                 ow
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/line_buffer_kxk.sv
// line_buffer_kxk: K-1 row line buffers plus a KxK sliding window.
// Ports: clk, rst (sync, active low), en (pixel accepted), data_in;
// window (flat KxK, element i*K+j, [0][0] oldest), window_valid,
// row/col (coordinates of the next pixel to be accepted).
module line_buffer_kxk
    import conv_pkg::*;
#(
    parameter int word_length = 8,
    parameter int kernel_size = 5,
    parameter int image_size  = 36,
    parameter int col_length  = 8
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          en,
    input  logic [word_length-1:0]                        data_in,
    output logic [kernel_size*kernel_size*word_length-1:0] window,
    output logic                                          window_valid,
    output logic [col_length-1:0]                         row,
    output logic [col_length-1:0]                         col
);

    localparam int K = kernel_size;
    localparam int N = image_size;
    localparam int L = (K - 1) * N;
    localparam logic [col_length-1:0] KM1 = col_length'(K - 1);
    localparam logic [col_length-1:0] NM1 = col_length'(N - 1);
    localparam logic [col_length-1:0] ONE = col_length'(1);

    logic [word_length-1:0] sr      [L];
    logic [word_length-1:0] win     [K][K];
    logic [word_length-1:0] new_col [K];

    // One long shift chain: tap j*N-1 is the same column j rows back.
    always_comb begin
        for (int i = 0; i < K; i++) begin
            new_col[i] = data_in;
        end
        for (int j = 1; j < K; j++) begin
            new_col[K-1-j] = sr[j*N-1];
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            sr[0] <= data_in;
            for (int i = 1; i < L; i++) begin
                sr[i] <= sr[i-1];
            end
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K - 1; j++) begin
                    win[i][j] <= win[i][j+1];
                end
                win[i][K-1] <= new_col[i];
            end
        end
    end

    for (genvar i = 0; i < K; i++) begin : g_row
        for (genvar j = 0; j < K; j++) begin : g_col
            assign window[(i*K+j)*word_length +: word_length] = win[i][j];
        end
    end

    // Window is complete only once a full KxK block sits left/above.
    always_ff @(posedge clk) begin
        if (!rst) begin
            row          <= '0;
            col          <= '0;
            window_valid <= 1'b0;
        end else begin
            window_valid <= en && (row >= KM1) && (col >= KM1);
            if (en) begin
                if (col == NM1) begin
                    col <= '0;
                    row <= (row == NM1) ? '0 : row + ONE;
                end else begin
                    col <= col + ONE;
                end
            end
        end
    end

endmodule

// File: rtl/conv_stream_kxk.sv
// conv_stream_kxk: streaming signed KxK convolution with stride.
// Ports: clk, rst (sync, active low); w_valid/w_data weight load
// (the w_valid that leaves S_IDLE/S_READY only opens the load, it is
// not stored); relu_en; in_valid/data_in/in_ready pixel stream;
// weights_loaded; data_out/out_valid/out_last result stream;
// frame_done pulse.
module conv_stream_kxk
    import conv_pkg::*;
#(
    parameter int word_length = 8,
    parameter int kernel_size = 5,
    parameter int image_size  = 36,
    parameter int stride      = 1,
    parameter int out_width   = 16,
    parameter int col_length  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   w_valid,
    input  logic [word_length-1:0] w_data,
    input  logic                   relu_en,
    input  logic                   in_valid,
    input  logic [word_length-1:0] data_in,
    output logic                   in_ready,
    output logic                   weights_loaded,
    output logic [out_width-1:0]   data_out,
    output logic                   out_valid,
    output logic                   out_last,
    output logic                   frame_done
);

    localparam int K  = kernel_size;
    localparam int N  = image_size;
    localparam int S  = stride;
    localparam int KK = K * K;
    localparam int WL = word_length;
    localparam int PW = 2 * WL;
    localparam int A  = acc_width(WL, K);
    localparam int M  = out_dim(N, K, S);
    localparam int MM = M * M;
    localparam int IW = $clog2(KK);
    localparam int OW = (MM > 1) ? $clog2(MM) : 1;
    localparam int PH = (S > 1) ? $clog2(S) : 1;
    localparam logic [col_length-1:0] KM1 = col_length'(K - 1);
    localparam logic [col_length-1:0] NM1 = col_length'(N - 1);
    localparam logic [PH-1:0] SM1   = PH'(S - 1);
    localparam logic [IW-1:0] WLAST = IW'(KK - 1);
    localparam logic [OW-1:0] OLAST = OW'(MM - 1);

    state_t                 state;
    logic [IW-1:0]          w_idx;
    logic signed [WL-1:0]   w_q [KK];
    logic                   relu_q;
    logic                   last_seen;
    logic                   accept;
    logic                   last_pix;
    logic [KK*WL-1:0]       window;
    logic                   win_valid;
    logic [col_length-1:0]  row;
    logic [col_length-1:0]  col;
    logic [PH-1:0]          rph;
    logic [PH-1:0]          cph;
    logic                   phase_ok;
    logic                   fire;
    logic signed [PW-1:0]   prod_c [KK];
    logic signed [PW-1:0]   prod_q [KK];
    logic                   pv;
    logic signed [A-1:0]    sum_c;
    logic signed [A-1:0]    sum_q;
    logic                   sv;
    logic [OW-1:0]          out_cnt;

    assign in_ready = (state == S_READY) || (state == S_RUN);
    assign accept   = in_valid && in_ready;
    assign last_pix = (row == NM1) && (col == NM1);
    assign fire     = win_valid && phase_ok;

    line_buffer_kxk #(
        .word_length (word_length),
        .kernel_size (kernel_size),
        .image_size  (image_size),
        .col_length  (col_length)
    ) u_lb (
        .clk          (clk),
        .rst          (rst),
        .en           (accept),
        .data_in      (data_in),
        .window       (window),
        .window_valid (win_valid),
        .row          (row),
        .col          (col)
    );

    // Mod-S phases of the pixel being accepted; forced to 0 just
    // before the first full window so (r-K+1)%S and (c-K+1)%S start
    // at zero. phase_ok lines up with the window registered alongside.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cph      <= '0;
            rph      <= '0;
            phase_ok <= 1'b0;
        end else begin
            phase_ok <= accept && (cph == '0) && (rph == '0);
            if (accept) begin
                if (col < KM1 || col == NM1 || cph == SM1) begin
                    cph <= '0;
                end else begin
                    cph <= cph + PH'(1);
                end
                if (col == NM1) begin
                    if (row < KM1 || row == NM1 || rph == SM1) begin
                        rph <= '0;
                    end else begin
                        rph <= rph + PH'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= S_IDLE;
            w_idx          <= '0;
            weights_loaded <= 1'b0;
            relu_q         <= 1'b0;
            frame_done     <= 1'b0;
            last_seen      <= 1'b0;
            for (int i = 0; i < KK; i++) begin
                w_q[i] <= '0;
            end
        end else begin
            frame_done <= 1'b0;
            if (out_last) begin
                last_seen <= 1'b1;
            end
            unique case (state)
                S_IDLE: begin
                    if (w_valid) begin
                        w_idx <= '0;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_valid) begin
                        w_q[w_idx] <= w_data;
                        if (w_idx == WLAST) begin
                            w_idx          <= '0;
                            weights_loaded <= 1'b1;
                            state          <= S_READY;
                        end else begin
                            w_idx <= w_idx + IW'(1);
                        end
                    end
                end
                S_READY: begin
                    if (accept) begin
                        relu_q <= relu_en;
                        state  <= S_RUN;
                    end else if (w_valid) begin
                        weights_loaded <= 1'b0;
                        w_idx          <= '0;
                        state          <= S_LOAD;
                    end
                end
                S_RUN: begin
                    if (accept && last_pix) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // With stride, out_last may already be behind us.
                    if ((out_last || last_seen) && !win_valid && !pv && !sv) begin
                        frame_done <= 1'b1;
                        last_seen  <= 1'b0;
                        state      <= S_READY;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < KK; i++) begin
            prod_c[i] = PW'(w_q[i]) * PW'(signed'(window[i*WL +: WL]));
        end
    end

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < KK; i++) begin
            sum_c = sum_c + A'(prod_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (fire) begin
            for (int i = 0; i < KK; i++) begin
                prod_q[i] <= prod_c[i];
            end
        end
        if (pv) begin
            sum_q <= sum_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pv        <= 1'b0;
            sv        <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            data_out  <= '0;
            out_cnt   <= '0;
        end else begin
            pv        <= fire;
            sv        <= pv;
            out_valid <= sv;
            out_last  <= sv && (out_cnt == OLAST);
            if (sv) begin
                if (relu_q && sum_q[A-1]) begin
                    data_out <= '0;
                end else begin
                    data_out <= out_width'(saturate(64'(sum_q), out_width));
                end
                out_cnt <= (out_cnt == OLAST) ? '0 : out_cnt + OW'(1);
            end
        end
    end

endmodule

// File: tb/tb_conv_stream_kxk.sv
// tb_conv_stream_kxk: directed bench for conv_stream_kxk (K=3).
// Three instances: N=6/S=1, N=7/S=2, N=4/S=1, selected by sel.
`timescale 1ns/1ps
module tb_conv_stream_kxk;

    localparam int NS [3] = '{6, 7, 4};
    localparam int SS [3] = '{1, 2, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        w_valid;
    logic        relu_en;
    logic        in_valid;
    logic [7:0]  w_data;
    logic [7:0]  data_in;
    int          sel;

    logic [2:0]  wv, iv, rdy, wl, ov, ol, fd;
    logic [15:0] dout [3];

    logic               o_ready, o_wl, o_valid, o_last, o_fd;
    logic signed [15:0] o_data;

    int n_checks = 0;
    int n_errors = 0;

    int pe = 0;
    int pcount = 0;
    int cur_n = 6;
    int cur_s = 1;
    int pr, pc;
    int got_q [$];
    int got_e [$];
    int acc_e [$];
    int exp_q [$];
    int last_pos = -1;
    int fd_edge = -1;

    assign wv = w_valid  ? (3'b001 << sel) : 3'b000;
    assign iv = in_valid ? (3'b001 << sel) : 3'b000;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        conv_stream_kxk #(
            .word_length (8),
            .kernel_size (3),
            .image_size  (NS[g]),
            .stride      (SS[g]),
            .out_width   (16),
            .col_length  (8)
        ) u_dut (
            .clk            (clk),
            .rst            (rst),
            .w_valid        (wv[g]),
            .w_data         (w_data),
            .relu_en        (relu_en),
            .in_valid       (iv[g]),
            .data_in        (data_in),
            .in_ready       (rdy[g]),
            .weights_loaded (wl[g]),
            .data_out       (dout[g]),
            .out_valid      (ov[g]),
            .out_last       (ol[g]),
            .frame_done     (fd[g])
        );
    end

    always_comb begin
        o_ready = rdy[sel];
        o_wl    = wl[sel];
        o_valid = ov[sel];
        o_last  = ol[sel];
        o_fd    = fd[sel];
        o_data  = dout[sel];
    end

    // Reference: edge on which each emitting pixel is accepted.
    always @(posedge clk) begin
        pe = pe + 1;
        if (!rst) begin
            pcount = 0;
        end else if (in_valid && o_ready) begin
            pr = pcount / cur_n;
            pc = pcount % cur_n;
            if (pr >= 2 && pc >= 2 && (pr - 2) % cur_s == 0 && (pc - 2) % cur_s == 0)
                acc_e.push_back(pe);
            pcount = (pcount + 1 == cur_n * cur_n) ? 0 : pcount + 1;
        end
    end

    always @(negedge clk) begin
        if (o_valid) begin
            got_q.push_back(int'(o_data));
            got_e.push_back(pe);
            if (o_last) last_pos = got_q.size();
        end
        if (o_fd) fd_edge = pe;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load_w(input int v, input bit center);
        @(negedge clk);
        w_valid = 1'b1;
        w_data  = 8'h00;
        for (int i = 0; i < 9; i++) begin
            if (i == 4) begin
                @(negedge clk);
                w_valid = 1'b0;
            end
            @(negedge clk);
            w_valid = 1'b1;
            w_data  = (center && i != 4) ? 8'd0 : 8'(v);
        end
        @(negedge clk);
        w_valid = 1'b0;
        check("weights_loaded", int'(o_wl), 1);
    endtask

    task automatic fill_exp(input int n, input int v);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    task automatic run_frame(input string tag, input int n, input int s,
                             input bit ramp, input int val, input bit gap,
                             input bit relu, input bit poke);
        int k;
        int ph;
        cur_n = n;
        cur_s = s;
        got_q.delete();
        got_e.delete();
        acc_e.delete();
        last_pos = -1;
        fd_edge  = -1;
        k  = 0;
        ph = 0;
        while (k < n * n) begin
            @(negedge clk);
            if (gap && ph == 1) begin
                in_valid = 1'b0;
                w_valid  = 1'b0;
            end else begin
                in_valid = 1'b1;
                relu_en  = relu;
                w_valid  = poke;
                w_data   = 8'd5;
                data_in  = ramp ? 8'(k) : 8'(val);
                k++;
            end
            ph = 1 - ph;
        end
        @(negedge clk);
        in_valid = 1'b0;
        w_valid  = 1'b0;
        for (int t = 0; t < 40 && fd_edge < 0; t++) @(posedge clk);
        @(negedge clk);
        check({tag, "_done_seen"}, int'(fd_edge >= 0), 1);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_val%0d", tag, i), got_q[i], exp_q[i]);
            if (i < acc_e.size())
                check($sformatf("%s_lat%0d", tag, i), got_e[i] - acc_e[i], 3);
        end
        check({tag, "_last_pos"}, last_pos, exp_q.size());
        if (got_e.size() > 0)
            check({tag, "_done_lat"}, fd_edge - got_e[got_e.size()-1], 1);
        check({tag, "_ready_after"}, int'(o_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst      = 1'b0;
        w_valid  = 1'b0;
        w_data   = '0;
        relu_en  = 1'b0;
        in_valid = 1'b0;
        data_in  = '0;
        sel      = 0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", int'(o_valid), 0);
        check("rst_out_last", int'(o_last), 0);
        check("rst_frame_done", int'(o_fd), 0);
        check("rst_in_ready", int'(o_ready), 0);
        check("rst_wl", int'(o_wl), 0);
        check("rst_data", int'(o_data), 0);
        rst = 1'b1;

        load_w(1, 1'b0);
        fill_exp(16, 9);
        run_frame("s1", 6, 1, 1'b0, 1, 1'b0, 1'b0, 1'b0);
        run_frame("s4", 6, 1, 1'b0, 1, 1'b1, 1'b0, 1'b0);

        load_w(2, 1'b0);
        fill_exp(16, 18);
        run_frame("s5", 6, 1, 1'b0, 1, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            data_in  = 8'd1;
            relu_en  = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        check("s6_rst_valid", int'(o_valid), 0);
        check("s6_rst_wl", int'(o_wl), 0);
        check("s6_rst_ready", int'(o_ready), 0);
        check("s6_rst_data", int'(o_data), 0);
        rst = 1'b1;
        load_w(1, 1'b0);
        fill_exp(16, 9);
        run_frame("s6", 6, 1, 1'b0, 1, 1'b0, 1'b0, 1'b0);

        sel = 1;
        load_w(1, 1'b1);
        exp_q = '{8, 10, 12, 22, 24, 26, 36, 38, 40};
        run_frame("s2", 7, 2, 1'b1, 0, 1'b0, 1'b0, 1'b0);

        sel = 2;
        load_w(127, 1'b0);
        fill_exp(4, 32767);
        run_frame("s3_pos", 4, 1, 1'b0, 127, 1'b0, 1'b0, 1'b0);
        load_w(-128, 1'b0);
        fill_exp(4, 0);
        run_frame("s3_relu", 4, 1, 1'b0, 127, 1'b0, 1'b1, 1'b0);
        fill_exp(4, -32768);
        run_frame("s3_neg", 4, 1, 1'b0, 127, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
